spi_cmd_ctrl: RTL and testbench
===============================

# spi_cmd_ctrl

Command sequencer between the SPI slave front end (command shifter on the command chip-select, 16-bit data shifter on the data chip-select) and the user register bank / data FIFO. It decodes the 8-bit command byte into a direction and a target address. It turns each received 16-bit data word into a register or FIFO write. It fetches the next transmit word on demand when the master starts a read transfer. It also tracks protocol and FIFO errors in sticky flags.

## Interface
- FIFO_ADDR, 7'd4, command address that maps to the data FIFO instead of the register bank
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  one-cycle pulse: command byte received (command CS deasserted)
- cmd  in  8  command byte; bit7 = read (1) / write (0), bits[6:0] = address
- wr_valid  in  1  one-cycle pulse: 16-bit data word received from master
- wr_data  in  16  received data word
- rd_start  in  1  one-cycle pulse: data CS asserted, master about to clock out a word
- rd_done  in  1  one-cycle pulse: 16 bits shifted out, word consumed
- reg_we / reg_re  out  1  register bank write / read strobe (one cycle)
- reg_addr  out  7  register address
- reg_wdata  out  16  register write data
- reg_rdata  in  16  register read data, valid 1 cycle after reg_re
- fifo_wr / fifo_rd  out  1  FIFO push / pop strobe (one cycle)
- fifo_wdata  out  16  FIFO push data
- fifo_rdata  in  16  FIFO pop data, valid 1 cycle after fifo_rd
- fifo_full / fifo_empty  in  1  FIFO status
- tx_data  out  16  word for the SPI shifter to transmit
- tx_valid  out  1  tx_data holds a fresh word
- err_ovf / err_udf / err_proto  out  1  sticky: FIFO overflow, FIFO underflow, protocol error
- busy  out  1  read fetch in progress

## Operation
- States: IDLE, WR, RD, FETCH, CAPT. Reset → IDLE; all strobes 0, tx_data 16'h0000, tx_valid 0, error flags 0, latched address 0.
- cmd_valid in any state: latch cmd[6:0] as address. Drop any unconsumed tx word (tx_valid ← 0), then branch:
  - cmd == 8'h00: clear all three error flags, go to IDLE.
  - cmd[7] = 0 (other values): go to WR.
  - cmd[7] = 1: go to RD.
  - cmd_valid has priority over wr_valid / rd_start / rd_done in the same cycle; those are ignored that cycle.
- WR, on wr_valid:
  - address ≠ FIFO_ADDR: reg_we = 1, reg_addr = address, reg_wdata = wr_data.
  - address = FIFO_ADDR and !fifo_full: fifo_wr = 1, fifo_wdata = wr_data.
  - address = FIFO_ADDR and fifo_full: no push, word dropped, err_ovf ← 1.
  - Stay in WR. Multiple words stream to the same address; there is no auto-increment.
- RD, on rd_start: go to FETCH.
- FETCH (one cycle):
  - address ≠ FIFO_ADDR: assert reg_re with reg_addr.
  - address = FIFO_ADDR and !fifo_empty: assert fifo_rd.
  - address = FIFO_ADDR and fifo_empty: no pop; err_udf ← 1; tx_data will be 16'h0000.
  - Go to CAPT.
- CAPT (one cycle): tx_data ← reg_rdata, fifo_rdata, or 16'h0000 per the FETCH decision; tx_valid ← 1; return to RD.
- RD, on rd_done: tx_valid ← 0.
- Protocol errors set err_proto and are otherwise ignored:
  - wr_valid in IDLE, RD, FETCH or CAPT.
  - rd_start in IDLE, WR, FETCH or CAPT.
  - rd_done while tx_valid = 0.
- busy = 1 in FETCH and CAPT only.

## Timing
- Write: wr_valid at cycle N → reg_we/fifo_wr at cycle N+1, for exactly one cycle.
- Read: rd_start at cycle N → FETCH at N+1 (reg_re/fifo_rd high) → CAPT at N+2 → tx_valid = 1 and tx_data stable from N+3. The SPI front end guarantees at least 4 clk cycles between CS assertion and the first shift edge.
- Each read transfer issues exactly one reg_re or fifo_rd. A FIFO is never popped ahead of demand, so a new command loses no data.
- Error flags set on the cycle after the offending event and hold until rst or command 8'h00.
- rst asserted mid-fetch: strobes deassert on the next edge; no partial pop or write completes after reset.

## Test plan
- Register write/read: cmd 0x01, wr 16'h1234; cmd 0x02, wr 16'h0F0F → reg_we at N+1 with addr 1/2 and matching data. Then cmd 0x81, rd_start → reg_re addr 1 at N+1, tx_valid at N+3.
- FIFO stream: cmd 0x04, words 1..10 → 10 fifo_wr pulses, no reg_we. Then cmd 0x84 and 10 × (rd_start, rd_done) → 10 fifo_rd pulses, tx_data = 1..10 in order.
- Overflow/underflow: fifo_full=1 plus a FIFO write → no fifo_wr, err_ovf=1. fifo_empty=1 plus rd_start under 0x84 → no fifo_rd, tx_data=0, err_udf=1. Then cmd 0x00 → all flags 0.
- Protocol: wr_valid after reset with no command → err_proto=1, no strobe. rd_done with tx_valid=0 → err_proto=1.
- Priority: cmd_valid (0x83) coincident with wr_valid under write mode → no reg_we, state RD. An unconsumed tx word is dropped (tx_valid=0).
- Reset mid-fetch: rst in FETCH cycle → next cycle all strobes 0, tx_valid 0, state IDLE.

Source files
------------

// File: rtl/spi_cmd_ctrl_if.sv
// spi_cmd_ctrl_if
// Bundles every signal between the command sequencer and its neighbours:
// the SPI slave front end, the user register bank and the data FIFO.
//
// Handshake semantics: cmd_valid, wr_valid, rd_start and rd_done are
// single-cycle pulses with no backpressure. The qualified payload (cmd,
// wr_data) is valid only in the pulse cycle. Strobes going out (reg_we,
// reg_re, fifo_wr, fifo_rd) are also single-cycle. Read data (reg_rdata,
// fifo_rdata) is valid the cycle after its strobe.
//
// Modports:
//   master : the sequencer itself (drives strobes, tx word, flags)
//   slave  : front end / register bank / FIFO side (drives pulses, data)
// dbg_state exposes the sequencer state encoding for checkers.
interface spi_cmd_ctrl_if;
  logic        cmd_valid;
  logic [7:0]  cmd;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        rd_start;
  logic        rd_done;
  logic        reg_we;
  logic        reg_re;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        fifo_wr;
  logic        fifo_rd;
  logic [15:0] fifo_wdata;
  logic [15:0] fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        err_ovf;
  logic        err_udf;
  logic        err_proto;
  logic        busy;
  logic [2:0]  dbg_state;

  modport master (
    input  cmd_valid, cmd, wr_valid, wr_data, rd_start, rd_done,
    input  reg_rdata, fifo_rdata, fifo_full, fifo_empty,
    output reg_we, reg_re, reg_addr, reg_wdata,
    output fifo_wr, fifo_rd, fifo_wdata,
    output tx_data, tx_valid, err_ovf, err_udf, err_proto, busy, dbg_state
  );

  modport slave (
    output cmd_valid, cmd, wr_valid, wr_data, rd_start, rd_done,
    output reg_rdata, fifo_rdata, fifo_full, fifo_empty,
    input  reg_we, reg_re, reg_addr, reg_wdata,
    input  fifo_wr, fifo_rd, fifo_wdata,
    input  tx_data, tx_valid, err_ovf, err_udf, err_proto, busy, dbg_state
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl
// Command sequencer between the SPI slave front end and the register bank /
// data FIFO. Decodes the command byte into direction + address, turns each
// received data word into a register write or FIFO push, fetches one
// transmit word per read transfer, and keeps sticky error flags.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - spi_cmd_ctrl_if.master (all handshake, bus and status signals)
// Parameter:
//   FIFO_ADDR - command address that targets the FIFO instead of registers
//
// State encoding (visible on bus.dbg_state):
//   IDLE=0, WR=1, RD=2, FETCH=3, CAPT=4
module spi_cmd_ctrl #(
  parameter logic [6:0] FIFO_ADDR = 7'd4
) (
  input  logic           clk,
  input  logic           rst,
  spi_cmd_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    FETCH = 3'd3,
    CAPT  = 3'd4
  } state_t;

  // Where CAPT takes the transmit word from; decided in FETCH.
  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_FIFO = 2'd1,
    SRC_ZERO = 2'd2
  } src_t;

  state_t      state_q, state_n;
  src_t        src_q, src_n;
  logic [6:0]  addr_q, addr_n;
  logic [15:0] wdata_q, wdata_n;
  logic [15:0] tx_data_q, tx_data_n;
  logic        tx_valid_q, tx_valid_n;
  logic        ovf_q, ovf_n;
  logic        udf_q, udf_n;
  logic        proto_q, proto_n;
  logic        reg_we_q, reg_we_n;
  logic        fifo_wr_q, fifo_wr_n;
  logic        is_fifo;

  assign is_fifo = (addr_q == FIFO_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= SRC_REG;
      addr_q     <= 7'd0;
      wdata_q    <= 16'h0000;
      tx_data_q  <= 16'h0000;
      tx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      proto_q    <= 1'b0;
      reg_we_q   <= 1'b0;
      fifo_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      src_q      <= src_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      tx_data_q  <= tx_data_n;
      tx_valid_q <= tx_valid_n;
      ovf_q      <= ovf_n;
      udf_q      <= udf_n;
      proto_q    <= proto_n;
      reg_we_q   <= reg_we_n;
      fifo_wr_q  <= fifo_wr_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    src_n      = src_q;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    tx_data_n  = tx_data_q;
    tx_valid_n = tx_valid_q;
    ovf_n      = ovf_q;
    udf_n      = udf_q;
    proto_n    = proto_q;
    reg_we_n   = 1'b0;
    fifo_wr_n  = 1'b0;

    if (bus.cmd_valid) begin
      // A new command wins over every other event this cycle and discards
      // any transmit word the master never clocked out.
      addr_n     = bus.cmd[6:0];
      tx_valid_n = 1'b0;
      if (bus.cmd == 8'h00) begin
        ovf_n   = 1'b0;
        udf_n   = 1'b0;
        proto_n = 1'b0;
        state_n = IDLE;
      end else if (!bus.cmd[7]) begin
        state_n = WR;
      end else begin
        state_n = RD;
      end
    end else begin
      case (state_q)
        IDLE: ;
        WR: begin
          if (bus.wr_valid) begin
            wdata_n = bus.wr_data;
            if (!is_fifo)            reg_we_n  = 1'b1;
            else if (!bus.fifo_full) fifo_wr_n = 1'b1;
            else                     ovf_n     = 1'b1;
          end
        end
        RD: begin
          if (bus.rd_start) state_n = FETCH;
        end
        FETCH: begin
          // The pop/read strobe is driven combinationally in this state;
          // remember which source CAPT has to sample.
          if (!is_fifo)             src_n = SRC_REG;
          else if (!bus.fifo_empty) src_n = SRC_FIFO;
          else begin
            src_n = SRC_ZERO;
            udf_n = 1'b1;
          end
          state_n = CAPT;
        end
        CAPT: begin
          case (src_q)
            SRC_REG:  tx_data_n = bus.reg_rdata;
            SRC_FIFO: tx_data_n = bus.fifo_rdata;
            default:  tx_data_n = 16'h0000;
          endcase
          tx_valid_n = 1'b1;
          state_n    = RD;
        end
        default: state_n = IDLE;
      endcase

      if (bus.wr_valid && (state_q != WR)) proto_n = 1'b1;
      if (bus.rd_start && (state_q != RD)) proto_n = 1'b1;
      if (bus.rd_done) begin
        if (!tx_valid_q)         proto_n    = 1'b1;
        else if (state_q == RD)  tx_valid_n = 1'b0;
      end
    end
  end

  assign bus.reg_we     = reg_we_q;
  assign bus.reg_re     = (state_q == FETCH) && !is_fifo;
  assign bus.reg_addr   = addr_q;
  assign bus.reg_wdata  = wdata_q;
  assign bus.fifo_wr    = fifo_wr_q;
  assign bus.fifo_rd    = (state_q == FETCH) && is_fifo && !bus.fifo_empty;
  assign bus.fifo_wdata = wdata_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.err_ovf    = ovf_q;
  assign bus.err_udf    = udf_q;
  assign bus.err_proto  = proto_q;
  assign bus.busy       = (state_q == FETCH) || (state_q == CAPT);
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl
// Cycle table of {inputs, expected outputs} for the register path, error
// flags, protocol errors and command priority, followed by hand-written
// sequences for FIFO streaming through a small FIFO model and reset during
// a fetch. Inputs change just after the rising edge; outputs are sampled on
// the falling edge of the same cycle.
module tb_spi_cmd_ctrl;

  localparam int NV = 39;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_cmd_ctrl_if bus();

  spi_cmd_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- FIFO environment model ----------------
  logic        env_on    = 1'b0;
  logic        env_empty = 1'b1;
  logic [15:0] env_rdata = 16'h0000;
  logic [15:0] env_fifo[$];
  logic        drv_empty;
  logic [15:0] drv_frdata;
  int          n_fwr = 0;
  int          n_frd = 0;
  int          n_we  = 0;
  int          n_re  = 0;

  assign bus.fifo_empty = env_on ? env_empty : drv_empty;
  assign bus.fifo_rdata = env_on ? env_rdata : drv_frdata;

  always @(negedge clk) begin
    if (env_on) begin
      if (bus.fifo_wr) begin
        env_fifo.push_back(bus.fifo_wdata);
        n_fwr++;
      end
      if (bus.fifo_rd) begin
        if (env_fifo.size() > 0) env_rdata = env_fifo.pop_front();
        n_frd++;
      end
      if (bus.reg_we) n_we++;
      if (bus.reg_re) n_re++;
    end
  end

  always @(posedge clk) env_empty <= (env_fifo.size() == 0);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] flags();
    return {bus.reg_we, bus.reg_re, bus.fifo_wr, bus.fifo_rd, bus.busy,
            bus.tx_valid, bus.err_ovf, bus.err_udf, bus.err_proto};
  endfunction

  // ---------------- vector table ----------------
  // fl order: {reg_we, reg_re, fifo_wr, fifo_rd, busy, tx_valid, ovf, udf, proto}
  typedef struct {
    logic        cv;
    logic [7:0]  cmd;
    logic        wv;
    logic [15:0] wd;
    logic        rs;
    logic        rdn;
    logic        full;
    logic        empty;
    logic [15:0] rr;
    logic [8:0]  fl;
    logic [2:0]  st;
    logic [6:0]  addr;
    logic [15:0] txd;
    logic [15:0] wdat;
  } vec_t;

  vec_t tbl[NV];

  function automatic vec_t mk(logic cv, logic [7:0] cmd, logic wv, logic [15:0] wd,
                              logic rs, logic rdn, logic full, logic empty,
                              logic [15:0] rr, logic [8:0] fl, logic [2:0] st,
                              logic [6:0] addr, logic [15:0] txd, logic [15:0] wdat);
    vec_t v;
    v.cv = cv; v.cmd = cmd; v.wv = wv; v.wd = wd; v.rs = rs; v.rdn = rdn;
    v.full = full; v.empty = empty; v.rr = rr; v.fl = fl; v.st = st;
    v.addr = addr; v.txd = txd; v.wdat = wdat;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd       = 8'h00;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 16'h0000;
    bus.rd_start  = 1'b0;
    bus.rd_done   = 1'b0;
    bus.reg_rdata = 16'h0000;
    bus.fifo_full = 1'b0;
    drv_empty     = 1'b0;
    drv_frdata    = 16'hDEAD;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    next_cycle();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int idx);
    bus.wr_valid = 1'b1;
    bus.wr_data  = w;
    next_cycle();
    bus.wr_valid = 1'b0;
    exp_q.push_back(w);
    @(negedge clk);
    chk($sformatf("stream_wr%0d_strobes", idx), {30'd0, bus.fifo_wr, bus.reg_we}, 32'd2);
    chk($sformatf("stream_wr%0d_data", idx), {16'd0, bus.fifo_wdata}, {16'd0, w});
    next_cycle();
  endtask

  task automatic read_word(input int idx);
    int lat;
    logic [15:0] exp_w;
    bus.rd_start = 1'b1;
    next_cycle();
    bus.rd_start = 1'b0;
    lat = 0;
    while (lat < 6) begin
      @(negedge clk);
      if (bus.tx_valid) break;
      next_cycle();
      lat++;
    end
    chk($sformatf("stream_rd%0d_latency", idx), lat, 32'd2);
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
    chk($sformatf("stream_rd%0d_data", idx), {16'd0, bus.tx_data}, {16'd0, exp_w});
    if (lat < 6) next_cycle();
    bus.rd_done = 1'b1;
    next_cycle();
    bus.rd_done = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    //              cv cmd    wv wd        rs rdn fu em rr        fl            st  ad    txd       wdat
    tbl[0]  = mk(0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000000000, 0, 7'd0, 16'h0000, 16'h0000);
    tbl[1]  = mk(0, 8'h00, 1, 16'hAAAA, 0, 0, 0, 0, 16'h0000, 9'b000000000, 0, 7'd0, 16'h0000, 16'h0000);
    tbl[2]  = mk(0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000000001, 0, 7'd0, 16'h0000, 16'h0000);
    tbl[3]  = mk(1, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000000001, 0, 7'd0, 16'h0000, 16'h0000);
    tbl[4]  = mk(1, 8'h01, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000000000, 0, 7'd0, 16'h0000, 16'h0000);
    tbl[5]  = mk(0, 8'h00, 1, 16'h1234, 0, 0, 0, 0, 16'h0000, 9'b000000000, 1, 7'd1, 16'h0000, 16'h0000);
    tbl[6]  = mk(1, 8'h02, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b100000000, 1, 7'd1, 16'h0000, 16'h1234);
    tbl[7]  = mk(0, 8'h00, 1, 16'h0F0F, 0, 0, 0, 0, 16'h0000, 9'b000000000, 1, 7'd2, 16'h0000, 16'h0000);
    tbl[8]  = mk(1, 8'h81, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b100000000, 1, 7'd2, 16'h0000, 16'h0F0F);
    tbl[9]  = mk(0, 8'h00, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 9'b000000000, 2, 7'd1, 16'h0000, 16'h0000);
    tbl[10] = mk(0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b010010000, 3, 7'd1, 16'h0000, 16'h0000);
    tbl[11] = mk(0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'hBEEF, 9'b000010000, 4, 7'd1, 16'h0000, 16'h0000);
    tbl[12] = mk(0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000001000, 2, 7'd1, 16'hBEEF, 16'h0000);
    tbl[13] = mk(0, 8'h00, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 9'b000001000, 2, 7'd1, 16'hBEEF, 16'h0000);
    tbl[14] = mk(0, 8'h00, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 9'b000000000, 2, 7'd1, 16'hBEEF, 16'h0000);
    tbl[15] = mk(0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000000001, 2, 7'd1, 16'hBEEF, 16'h0000);
    tbl[16] = mk(1, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000000001, 2, 7'd1, 16'hBEEF, 16'h0000);
    tbl[17] = mk(1, 8'h04, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000000000, 0, 7'd0, 16'hBEEF, 16'h0000);
    tbl[18] = mk(0, 8'h00, 1, 16'h5555, 0, 0, 1, 0, 16'h0000, 9'b000000000, 1, 7'd4, 16'hBEEF, 16'h0000);
    tbl[19] = mk(0, 8'h00, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 9'b000000100, 1, 7'd4, 16'hBEEF, 16'h0000);
    tbl[20] = mk(0, 8'h00, 1, 16'h6666, 0, 0, 0, 0, 16'h0000, 9'b000000100, 1, 7'd4, 16'hBEEF, 16'h0000);
    tbl[21] = mk(1, 8'h84, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b001000100, 1, 7'd4, 16'hBEEF, 16'h6666);
    tbl[22] = mk(0, 8'h00, 0, 16'h0000, 1, 0, 0, 1, 16'h0000, 9'b000000100, 2, 7'd4, 16'hBEEF, 16'h0000);
    tbl[23] = mk(0, 8'h00, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 9'b000010100, 3, 7'd4, 16'hBEEF, 16'h0000);
    tbl[24] = mk(0, 8'h00, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 9'b000010110, 4, 7'd4, 16'hBEEF, 16'h0000);
    tbl[25] = mk(0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000001110, 2, 7'd4, 16'h0000, 16'h0000);
    tbl[26] = mk(1, 8'h03, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000001110, 2, 7'd4, 16'h0000, 16'h0000);
    tbl[27] = mk(0, 8'h00, 1, 16'h7777, 0, 0, 0, 0, 16'h0000, 9'b000000110, 1, 7'd3, 16'h0000, 16'h0000);
    tbl[28] = mk(1, 8'h83, 1, 16'h1111, 0, 0, 0, 0, 16'h0000, 9'b100000110, 1, 7'd3, 16'h0000, 16'h7777);
    tbl[29] = mk(0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000000110, 2, 7'd3, 16'h0000, 16'h0000);
    tbl[30] = mk(0, 8'h00, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 9'b000000110, 2, 7'd3, 16'h0000, 16'h0000);
    tbl[31] = mk(0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b010010110, 3, 7'd3, 16'h0000, 16'h0000);
    tbl[32] = mk(0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h00C3, 9'b000010110, 4, 7'd3, 16'h0000, 16'h0000);
    tbl[33] = mk(1, 8'h83, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000001110, 2, 7'd3, 16'h00C3, 16'h0000);
    tbl[34] = mk(0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000000110, 2, 7'd3, 16'h00C3, 16'h0000);
    tbl[35] = mk(1, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000000110, 2, 7'd3, 16'h00C3, 16'h0000);
    tbl[36] = mk(1, 8'h05, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000000000, 0, 7'd0, 16'h00C3, 16'h0000);
    tbl[37] = mk(0, 8'h00, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 9'b000000000, 1, 7'd5, 16'h00C3, 16'h0000);
    tbl[38] = mk(0, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 9'b000000001, 1, 7'd5, 16'h00C3, 16'h0000);

    // Clock/reset
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven cycles
    for (int i = 0; i < NV; i++) begin
      bus.cmd_valid = tbl[i].cv;
      bus.cmd       = tbl[i].cmd;
      bus.wr_valid  = tbl[i].wv;
      bus.wr_data   = tbl[i].wd;
      bus.rd_start  = tbl[i].rs;
      bus.rd_done   = tbl[i].rdn;
      bus.fifo_full = tbl[i].full;
      drv_empty     = tbl[i].empty;
      bus.reg_rdata = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("row%0d_flags", i), {23'd0, flags()}, {23'd0, tbl[i].fl});
      chk($sformatf("row%0d_state", i), {29'd0, bus.dbg_state}, {29'd0, tbl[i].st});
      chk($sformatf("row%0d_addr", i), {25'd0, bus.reg_addr}, {25'd0, tbl[i].addr});
      chk($sformatf("row%0d_tx_data", i), {16'd0, bus.tx_data}, {16'd0, tbl[i].txd});
      if (tbl[i].fl[8]) chk($sformatf("row%0d_reg_wdata", i), {16'd0, bus.reg_wdata}, {16'd0, tbl[i].wdat});
      if (tbl[i].fl[6]) chk($sformatf("row%0d_fifo_wdata", i), {16'd0, bus.fifo_wdata}, {16'd0, tbl[i].wdat});
      next_cycle();
    end
    clear_inputs();

    // FIFO stream: 10 pushes then 10 single-word reads through the model
    send_cmd(8'h00);
    env_on = 1'b1;
    send_cmd(8'h04);
    for (int i = 1; i <= 10; i++) send_word(16'(i), i);
    send_cmd(8'h84);
    for (int i = 1; i <= 10; i++) read_word(i);
    @(negedge clk);
    chk("stream_fifo_wr_count", n_fwr, 32'd10);
    chk("stream_fifo_rd_count", n_frd, 32'd10);
    chk("stream_reg_we_count", n_we, 32'd0);
    chk("stream_reg_re_count", n_re, 32'd0);
    chk("stream_errors", {29'd0, bus.err_ovf, bus.err_udf, bus.err_proto}, 32'd0);
    chk("stream_model_empty", env_fifo.size(), 32'd0);
    next_cycle();
    env_on = 1'b0;

    // Reset asserted during a fetch
    send_cmd(8'h81);
    bus.rd_start = 1'b1;
    next_cycle();
    bus.rd_start = 1'b0;
    @(negedge clk);
    chk("rstfetch_before_flags", {23'd0, flags()}, {23'd0, 9'b010010000});
    chk("rstfetch_before_state", {29'd0, bus.dbg_state}, 32'd3);
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rstfetch_after_flags", {23'd0, flags()}, 32'd0);
    chk("rstfetch_after_state", {29'd0, bus.dbg_state}, 32'd0);
    chk("rstfetch_after_addr", {25'd0, bus.reg_addr}, 32'd0);
    chk("rstfetch_after_tx_data", {16'd0, bus.tx_data}, 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
